// File: rtl/secret_accum_multi.sv
// rtl/secret_accum_multi.sv - per-channel accumulators with secret offset, bypass mux and pass-through delay line
// Optional feature macro: SECRET_ACCUM_SAT_EN (saturate accumulator on overflow instead of wrapping).
module secret_accum_multi #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 2,
    parameter int SECRET    = 7,
    parameter int PT_WIDTH  = 129,
    parameter int PT_STAGES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       bypass,
    input  logic [CHANNELS*WIDTH-1:0] accum_in,
    output logic [CHANNELS*WIDTH-1:0] accum_out,
    output logic [CHANNELS*WIDTH-1:0] bypass_out,
    output logic [CHANNELS*16-1:0]    count,
    output logic [CHANNELS-1:0]       overflow,
    input  logic [PT_WIDTH-1:0]       pt_in,
    output logic [PT_WIDTH-1:0]       pt_out
);

    localparam logic [WIDTH-1:0] SECRET_W = WIDTH'(SECRET);

    logic [WIDTH-1:0]   accum_q [CHANNELS];
    logic [WIDTH-1:0]   accum_d [CHANNELS];
    logic [15:0]        count_q [CHANNELS];
    logic [15:0]        count_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [WIDTH+1:0]   sum     [CHANNELS];
    logic [CHANNELS-1:0] sum_ovf;

    // Two guard bits make the carry out of accum + data + secret visible.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c]     = {2'b00, accum_q[c]} + {2'b00, accum_in[c*WIDTH +: WIDTH]} + {2'b00, SECRET_W};
            sum_ovf[c] = |sum[c][WIDTH+1:WIDTH];
            accum_d[c] = accum_q[c];
            count_d[c] = count_q[c];
            ovf_d[c]   = ovf_q[c];
            if (clear[c]) begin
                accum_d[c] = '0;
                count_d[c] = '0;
                ovf_d[c]   = 1'b0;
            end else if (in_valid[c]) begin
`ifdef SECRET_ACCUM_SAT_EN
                accum_d[c] = sum_ovf[c] ? '1 : sum[c][WIDTH-1:0];
`else
                accum_d[c] = sum[c][WIDTH-1:0];
`endif
                count_d[c] = (count_q[c] == 16'hFFFF) ? count_q[c] : count_q[c] + 16'd1;
                ovf_d[c]   = ovf_q[c] | sum_ovf[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                accum_q[c] <= '0;
                count_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                accum_q[c] <= accum_d[c];
                count_q[c] <= count_d[c];
            end
            ovf_q <= ovf_d;
        end
    end

    // Status outputs read as zero for the whole time reset is held, even before the first edge.
    always_comb begin
        accum_out = '0;
        count     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            accum_out[c*WIDTH +: WIDTH] = rst_n ? accum_q[c] : '0;
            count[c*16 +: 16]           = rst_n ? count_q[c] : 16'd0;
        end
        overflow = rst_n ? ovf_q : '0;
    end

    always_comb begin
        bypass_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bypass_out[c*WIDTH +: WIDTH] = bypass[c] ? accum_in[c*WIDTH +: WIDTH]
                                                     : accum_out[c*WIDTH +: WIDTH];
        end
    end

    generate
        if (PT_STAGES == 0) begin : g_pt_comb
            assign pt_out = pt_in;
        end else begin : g_pt_reg
            logic [PT_WIDTH-1:0] pt_q [PT_STAGES];
            logic [PT_WIDTH-1:0] pt_d [PT_STAGES];

            always_comb begin
                pt_d[0] = pt_in;
                for (int s = 1; s < PT_STAGES; s++) begin
                    pt_d[s] = pt_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int s = 0; s < PT_STAGES; s++) begin
                    pt_q[s] <= rst_n ? pt_d[s] : '0;
                end
            end

            assign pt_out = pt_q[PT_STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_secret_accum_multi.sv
// tb/tb_secret_accum_multi.sv - scoreboard bench for secret_accum_multi (WIDTH=8, two channels, 3-stage and 0-stage pass-through)
module tb_secret_accum_multi;

    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int SEC = 7;
    localparam int PTW = 129;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     clear = '0;
    logic [CH-1:0]     bypass = '0;
    logic [CH*W-1:0]   accum_in = '0;
    logic [PTW-1:0]    pt_in = '0;

    logic [CH*W-1:0]   accum_out, bypass_out, accum_out0, bypass_out0;
    logic [CH*16-1:0]  count, count0;
    logic [CH-1:0]     overflow, overflow0;
    logic [PTW-1:0]    pt_out, pt_out0;

    always #5 clk = ~clk;

    secret_accum_multi #(.WIDTH(W), .CHANNELS(CH), .SECRET(SEC), .PT_WIDTH(PTW), .PT_STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clear(clear), .bypass(bypass),
        .accum_in(accum_in), .accum_out(accum_out), .bypass_out(bypass_out),
        .count(count), .overflow(overflow), .pt_in(pt_in), .pt_out(pt_out)
    );

    secret_accum_multi #(.WIDTH(W), .CHANNELS(CH), .SECRET(SEC), .PT_WIDTH(PTW), .PT_STAGES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clear(clear), .bypass(bypass),
        .accum_in(accum_in), .accum_out(accum_out0), .bypass_out(bypass_out0),
        .count(count0), .overflow(overflow0), .pt_in(pt_in), .pt_out(pt_out0)
    );

    typedef struct {
        logic [CH*W-1:0]  acc;
        logic [CH*16-1:0] cnt;
        logic [CH-1:0]    ovf;
        logic [CH*W-1:0]  byp;
        logic [PTW-1:0]   pt;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state kept as plain integers.
    int             m_acc [CH];
    int             m_cnt [CH];
    bit             m_ovf [CH];
    logic [PTW-1:0] pt_hist[$];
    logic [63:0]    lfsr = 64'h1234_5678_9ABC_DEF1;

    task automatic chk(input string name, input logic [PTW-1:0] act, input logic [PTW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] v, input logic [1:0] c,
                        input logic [1:0] b, input logic [7:0] d0, input logic [7:0] d1);
        exp_t e;
        int   s;
        int   dd;
        @(negedge clk);
        lfsr     = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
        rst_n    = r;
        in_valid = v;
        clear    = c;
        bypass   = b;
        accum_in = {d1, d0};
        pt_in    = {lfsr[0], lfsr, lfsr};

        if (!r) begin
            for (int ch = 0; ch < CH; ch++) begin
                m_acc[ch] = 0;
                m_cnt[ch] = 0;
                m_ovf[ch] = 0;
            end
            pt_hist = '{'0, '0, '0};
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                dd = (ch == 0) ? int'(d0) : int'(d1);
                if (c[ch]) begin
                    m_acc[ch] = 0;
                    m_cnt[ch] = 0;
                    m_ovf[ch] = 0;
                end else if (v[ch]) begin
                    s = m_acc[ch] + dd + (SEC % 256);
                    if (s > 255) begin
                        m_ovf[ch] = 1;
`ifdef SECRET_ACCUM_SAT_EN
                        s = 255;
`else
                        s = s % 256;
`endif
                    end
                    m_acc[ch] = s;
                    if (m_cnt[ch] < 65535) m_cnt[ch] = m_cnt[ch] + 1;
                end
            end
            pt_hist.push_front(pt_in);
            void'(pt_hist.pop_back());
        end

        for (int ch = 0; ch < CH; ch++) begin
            e.acc[ch*W +: W]   = 8'(m_acc[ch]);
            e.cnt[ch*16 +: 16] = 16'(m_cnt[ch]);
            e.ovf[ch]          = m_ovf[ch];
            e.byp[ch*W +: W]   = b[ch] ? ((ch == 0) ? d0 : d1) : 8'(m_acc[ch]);
        end
        e.pt = pt_hist[2];
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("accum_out", PTW'(accum_out), PTW'(e.acc));
                chk("count", PTW'(count), PTW'(e.cnt));
                chk("overflow", PTW'(overflow), PTW'(e.ovf));
                chk("bypass_out", PTW'(bypass_out), PTW'(e.byp));
                chk("pt_out_3stage", pt_out, e.pt);
                chk("pt_out_0stage", pt_out0, pt_in);
                chk("accum_out_pt0", PTW'(accum_out0), PTW'(e.acc));
            end
        end
    end

    initial begin : stimulus
        pt_hist = '{'0, '0, '0};
        for (int ch = 0; ch < CH; ch++) begin
            m_acc[ch] = 0;
            m_cnt[ch] = 0;
            m_ovf[ch] = 0;
        end

        step(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        step(0, 2'b11, 2'b00, 2'b00, 8'h11, 8'h22);
        // First accumulate lands on the edge that releases reset; second one overflows.
        step(1, 2'b01, 2'b00, 2'b00, 8'hF0, 8'h00);
        step(1, 2'b01, 2'b00, 2'b00, 8'hF0, 8'h00);
        step(1, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00);

        for (int i = 0; i < 10; i++) step(1, 2'b11, 2'b00, 2'b00, 8'(5 * i), 8'(100 + 5 * i));

        step(1, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00);
        step(1, 2'b11, 2'b00, 2'b00, 8'd35, 8'd92);
        step(1, 2'b01, 2'b01, 2'b00, 8'd9, 8'd9);

        for (int i = 0; i < 4; i++) step(1, 2'b10, 2'b00, 2'b10, 8'd0, 8'd125);
        step(1, 2'b10, 2'b00, 2'b00, 8'd0, 8'd125);

        for (int i = 0; i < 6; i++) step(1, 2'b11, 2'b00, 2'b00, 8'(3 + i), 8'(40 + i));
        step(0, 2'b11, 2'b00, 2'b00, 8'h55, 8'h66);
        for (int i = 0; i < 3; i++) step(1, 2'b11, 2'b00, 2'b00, 8'(10 + i), 8'(20 + i));

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), 2'($urandom), 
                 ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00,
                 2'($urandom), 8'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
